// File: rtl/ins_prefetch.sv
// Instruction prefetch stage: credit-limited memory requester feeding a small
// in-order FIFO of {pc, instruction}, with redirect flush and stale-response drop.
module ins_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] pc_addr_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_count_q, fifo_count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;

    logic [CW:0]     credit;
    logic [31:0]     jump_tgt;
    logic            accept;
    logic            rv;
    logic            drop;
    logic            push;
    logic            pop;
    entry_t          head;

    assign jump_tgt = jump_addr_i & 32'hFFFF_FFFC;
    assign credit   = {1'b0, fifo_count_q} + {1'b0, outstanding_q};

    // Reset gates the request combinationally so nothing is issued while rst is high.
    assign mem_req_o  = !rst && !jump_en_i && (credit < DEPTH_C);
    assign mem_addr_o = req_pc_q;
    assign accept     = mem_req_o && mem_gnt_i;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign rv   = mem_rvalid_i && (outstanding_q != '0);
    assign drop = rv && (jump_en_i || (drop_cnt_q != '0));
    assign push = rv && !drop;

    assign inst_valid_o = (fifo_count_q != '0);
    assign pop          = inst_valid_o && !hold_flag_i && !jump_en_i;
    assign head         = fifo_q[rd_ptr_q];
    assign inst_o       = inst_valid_o ? head.inst : NOP;
    assign pc_addr_o    = inst_valid_o ? head.pc   : 32'h0;

    always_comb begin
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_count_d  = fifo_count_q;
        drop_cnt_d    = drop_cnt_q;
        req_pc_d      = req_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(rv);

        if (accept) req_pc_d = req_pc_q + 32'd4;

        if (jump_en_i) begin
            // Everything still in flight belongs to the old stream and must be dropped.
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
            req_pc_d     = jump_tgt;
            resp_pc_d    = jump_tgt;
            drop_cnt_d   = outstanding_q - CW'(rv);
        end else begin
            if (rv && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: resp_pc_q, inst: mem_rdata_i};
                wr_ptr_d         = wr_ptr_q + 1'b1;
                resp_pc_d        = resp_pc_q + 32'd4;
            end
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
        end else begin
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
        end
    end

endmodule
